hpu_soft_reset_rsp: RTL and testbench

HPU_SOFT_RESET_RSP -- requirements
Module: hpu_soft_reset_rsp

---
 rtl/hpu_soft_reset_rsp.sv | 101 ++++++++++
 tb/tb_hpu_soft_reset_rsp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hpu_soft_reset_rsp.sv
// Soft-reset responder: synchronizes a request, sequences per-domain resets, 4-phase ack.
// Optional macro HPU_SOFT_RESET_RSP_CNT_EN adds the rst_cnt sequence counter output.
module hpu_soft_reset_rsp #(
    parameter int unsigned NB_DOM      = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic              prc_clk,
    input  logic              prc_srst,
    input  logic              soft_rst_req,
    output logic              soft_rst_ack,
    output logic [NB_DOM-1:0] dom_srst_n,
`ifdef HPU_SOFT_RESET_RSP_CNT_EN
    output logic [7:0]        rst_cnt,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [1:0] sync;
    logic [7:0] cnt;
    logic       req_s;

    assign req_s = sync[1];

    // dom_srst_n is a thermometer code: shifting in ones releases domains in ascending order
    always_ff @(posedge prc_clk) begin
        if (prc_srst) begin
            sync         <= '0;
            state        <= ASSERT;
            cnt          <= HOLD_LD;
            dom_srst_n   <= '0;
            soft_rst_ack <= 1'b0;
            busy         <= 1'b1;
`ifdef HPU_SOFT_RESET_RSP_CNT_EN
            rst_cnt      <= '0;
`endif
        end else begin
            sync <= {sync[0], soft_rst_req};
            case (state)
                IDLE: begin
                    if (req_s) begin
                        state      <= ASSERT;
                        cnt        <= HOLD_LD;
                        dom_srst_n <= '0;
                        busy       <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (cnt == 8'd0) begin
                        state      <= RELEASE;
                        dom_srst_n <= NB_DOM'(1);
                        cnt        <= GAP_LD;
`ifdef HPU_SOFT_RESET_RSP_CNT_EN
                        if (rst_cnt != 8'hFF)
                            rst_cnt <= rst_cnt + 8'd1;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RELEASE: begin
                    if (cnt == 8'd0) begin
                        if (dom_srst_n[NB_DOM-1]) begin
                            busy <= 1'b0;
                            if (req_s) begin
                                state        <= ACK;
                                soft_rst_ack <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            dom_srst_n <= NB_DOM'({dom_srst_n, 1'b1});
                            cnt        <= GAP_LD;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        state        <= IDLE;
                        soft_rst_ack <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpu_soft_reset_rsp.sv
// Directed self-checking bench for hpu_soft_reset_rsp with default parameters.
module tb_hpu_soft_reset_rsp;

    logic       clk = 1'b0;
    logic       srst;
    logic       req;
    logic       ack;
    logic [2:0] dom;
    logic       busy;
`ifdef HPU_SOFT_RESET_RSP_CNT_EN
    logic [7:0] rst_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        ack_seen;

    hpu_soft_reset_rsp #(
        .NB_DOM      (3),
        .HOLD_CYCLES (16),
        .GAP_CYCLES  (4)
    ) dut (
        .prc_clk      (clk),
        .prc_srst     (srst),
        .soft_rst_req (req),
        .soft_rst_ack (ack),
        .dom_srst_n   (dom),
`ifdef HPU_SOFT_RESET_RSP_CNT_EN
        .rst_cnt      (rst_cnt),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        srst = 1'b1;
        req  = 1'b0;

        // power-on: reset held 5 cycles, no request
        tick(5);
        check("rst_dom",  32'(dom),  32'h0);
        check("rst_ack",  32'(ack),  32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        srst = 1'b0;
        tick(15);
        check("po_hold15", 32'(dom), 32'h0);
        tick(1);
        check("po_rel0", 32'(dom), 32'h1);
        tick(3);
        check("po_gap0", 32'(dom), 32'h1);
        tick(1);
        check("po_rel1", 32'(dom), 32'h3);
        tick(4);
        check("po_rel2", 32'(dom), 32'h7);
        tick(3);
        check("po_busy27", 32'(busy), 32'h1);
        tick(1);
        check("po_busy28", 32'(busy), 32'h0);
        check("po_ack28",  32'(ack),  32'h0);
        tick(5);
        check("po_idle_dom", 32'(dom), 32'h7);

        // full handshake
        req = 1'b1;
        tick(2);
        check("hs_edge2", 32'(dom), 32'h7);
        tick(1);
        check("hs_edge3",  32'(dom),  32'h0);
        check("hs_busy3",  32'(busy), 32'h1);
        tick(15);
        check("hs_hold18", 32'(dom), 32'h0);
        tick(1);
        check("hs_rel0", 32'(dom), 32'h1);
        tick(4);
        check("hs_rel1", 32'(dom), 32'h3);
        tick(4);
        check("hs_rel2", 32'(dom), 32'h7);
        tick(3);
        check("hs_ack30", 32'(ack), 32'h0);
        tick(1);
        check("hs_ack31",  32'(ack),  32'h1);
        check("hs_busy31", 32'(busy), 32'h0);
        // held request in ACK, plus a sub-cycle glitch the synchronizer never samples
        tick(3);
        req = 1'b0;
        #3;
        req = 1'b1;
        tick(4);
        check("ack_glitch_ack", 32'(ack),  32'h1);
        check("ack_glitch_dom", 32'(dom),  32'h7);
        check("ack_glitch_bsy", 32'(busy), 32'h0);
        req = 1'b0;
        tick(2);
        check("hs_drop2", 32'(ack), 32'h1);
        tick(1);
        check("hs_drop3", 32'(ack), 32'h0);
        tick(3);
        check("hs_idle_dom", 32'(dom), 32'h7);
        check("hs_idle_bsy", 32'(busy), 32'h0);

        // early drop: request only 4 cycles, sequence still completes without ack
        req = 1'b1;
        ack_seen = 1'b0;
        tick(4);
        req = 1'b0;
        if (ack) ack_seen = 1'b1;
        for (int i = 5; i <= 27; i++) begin
            tick(1);
            if (ack) ack_seen = 1'b1;
        end
        check("ed_rel2_27",  32'(dom),  32'h7);
        check("ed_busy27",   32'(busy), 32'h1);
        for (int i = 28; i <= 40; i++) begin
            tick(1);
            if (ack) ack_seen = 1'b1;
        end
        check("ed_busy_end", 32'(busy),     32'h0);
        check("ed_no_ack",   32'(ack_seen), 32'h0);
        check("ed_idle_dom", 32'(dom),      32'h7);
`ifdef HPU_SOFT_RESET_RSP_CNT_EN
        check("cnt_three", 32'(rst_cnt), 32'd3);
`endif

        // mid-sequence reset while dom = 011
        req = 1'b1;
        tick(23);
        check("mr_pre", 32'(dom), 32'h3);
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        check("mr_dom",  32'(dom),  32'h0);
        check("mr_busy", 32'(busy), 32'h1);
        tick(15);
        check("mr_hold", 32'(dom), 32'h0);
        tick(1);
        check("mr_rel0", 32'(dom), 32'h1);
        tick(8);
        check("mr_rel2", 32'(dom), 32'h7);
        tick(3);
        check("mr_ack27", 32'(ack), 32'h0);
        tick(1);
        check("mr_ack28", 32'(ack), 32'h1);
        req = 1'b0;
        tick(3);
        check("mr_ack_off", 32'(ack),  32'h0);
        check("mr_idle",    32'(busy), 32'h0);
`ifdef HPU_SOFT_RESET_RSP_CNT_EN
        check("cnt_after_rst", 32'(rst_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
